// File: rtl/mem_stage.sv
// MEM pipeline stage: performs data-memory loads/stores over a req/ack handshake,
// resolves branches, and registers the fields handed to the MEM/WB register.
//
// state  | meaning
// IDLE   | accepting from EX/MEM; ALU ops and illegal accesses retire next edge
// WAIT   | memory request outstanding; upstream frozen until ack or timeout
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              flush_in,
    input  logic [DATA_W-1:0] BPC_in,
    input  logic [4:0]        gprDes_in,
    input  logic [DATA_W-1:0] aluOut_in,
    input  logic [DATA_W-1:0] gprB_in,
    input  logic              zero_in,
    input  logic              pcSel_in,
    input  logic              memR_in,
    input  logic              memW_in,
    input  logic              regW_in,
    input  logic              memToR_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic              br_take,
    output logic [DATA_W-1:0] br_target,
    output logic              wb_valid,
    output logic              wb_regW,
    output logic              wb_memToR,
    output logic [4:0]        wb_gprDes,
    output logic [DATA_W-1:0] wb_aluOut,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_regW;
    logic             r_memToR;
    logic [4:0]       r_gprDes;

    logic w_live;
    logic w_is_mem;
    logic w_illegal;
    logic w_issue;
    logic w_tmo;

    always_comb begin
        w_live    = valid_in & ~flush_in;
        w_is_mem  = memR_in | memW_in;
        w_illegal = (memR_in & memW_in) | (w_is_mem & (aluOut_in[1:0] != 2'b00));
        w_issue   = (r_state == S_IDLE) & w_live & w_is_mem & ~w_illegal;
        w_tmo     = (r_state == S_WAIT) & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next = S_WAIT;
            S_WAIT:  if (dmem_ack || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ack drops the stall in its own cycle so upstream advances on the completing edge.
    always_comb begin
        stall_out = w_issue | ((r_state == S_WAIT) & ~dmem_ack);
        br_take   = (r_state == S_IDLE) & w_live & pcSel_in & zero_in;
        br_target = BPC_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_regW    <= 1'b0;
            wb_memToR  <= 1'b0;
            wb_gprDes  <= '0;
            wb_aluOut  <= '0;
            wb_rdata   <= '0;
            err        <= 1'b0;
            r_cnt      <= '0;
            r_regW     <= 1'b0;
            r_memToR   <= 1'b0;
            r_gprDes   <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_regW  <= 1'b0;
            err      <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_live && (!w_is_mem || w_illegal)) begin
                    wb_valid  <= 1'b1;
                    wb_regW   <= regW_in & ~w_illegal;
                    err       <= w_illegal;
                    wb_memToR <= memToR_in;
                    wb_gprDes <= gprDes_in;
                    wb_aluOut <= aluOut_in;
                    wb_rdata  <= '0;
                end else if (w_issue) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= memW_in;
                    dmem_addr  <= aluOut_in;
                    dmem_wdata <= gprB_in;
                    r_regW     <= regW_in;
                    r_memToR   <= memToR_in;
                    r_gprDes   <= gprDes_in;
                    r_cnt      <= '0;
                end
            end else if (dmem_ack || w_tmo) begin
                // dmem_addr still holds the ALU result that formed the address.
                dmem_req  <= 1'b0;
                wb_valid  <= 1'b1;
                wb_regW   <= r_regW & dmem_ack;
                err       <= ~dmem_ack;
                wb_memToR <= r_memToR;
                wb_gprDes <= r_gprDes;
                wb_aluOut <= dmem_addr;
                wb_rdata  <= (dmem_ack && !dmem_we) ? dmem_rdata : '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected retirements into a queue,
// an independent monitor pops and compares on every wb_valid pulse.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, flush_in, zero_in, pcSel_in;
    logic        memR_in, memW_in, regW_in, memToR_in;
    logic [31:0] BPC_in, aluOut_in, gprB_in;
    logic [4:0]  gprDes_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_out, br_take;
    logic [31:0] br_target;
    logic        wb_valid, wb_regW, wb_memToR, err;
    logic [4:0]  wb_gprDes;
    logic [31:0] wb_aluOut, wb_rdata;

    mem_stage #(.DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .flush_in(flush_in), .BPC_in(BPC_in),
        .gprDes_in(gprDes_in), .aluOut_in(aluOut_in), .gprB_in(gprB_in),
        .zero_in(zero_in), .pcSel_in(pcSel_in),
        .memR_in(memR_in), .memW_in(memW_in), .regW_in(regW_in), .memToR_in(memToR_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .br_take(br_take), .br_target(br_target),
        .wb_valid(wb_valid), .wb_regW(wb_regW), .wb_memToR(wb_memToR),
        .wb_gprDes(wb_gprDes), .wb_aluOut(wb_aluOut), .wb_rdata(wb_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        regw;
        logic        memtor;
        logic [4:0]  des;
        logic [31:0] alu;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic e, input logic rw, input logic mtr,
                        input logic [4:0] des, input logic [31:0] alu, input logic [31:0] rd);
        exp_t x;
        x.err = e; x.regw = rw; x.memtor = mtr; x.des = des; x.alu = alu; x.rdata = rd;
        q.push_back(x);
    endtask

    // Monitor: every wb_valid pulse must match the oldest expected retirement.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wb_valid) begin
                    if (q.size() == 0) begin
                        chk("wb_unexpected", 32'(wb_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("wb_err", 32'(err), 32'(e.err));
                        chk("wb_regW", 32'(wb_regW), 32'(e.regw));
                        if (!e.err) begin
                            chk("wb_memToR", 32'(wb_memToR), 32'(e.memtor));
                            chk("wb_gprDes", 32'(wb_gprDes), 32'(e.des));
                            chk("wb_aluOut", wb_aluOut, e.alu);
                            chk("wb_rdata", wb_rdata, e.rdata);
                        end
                    end
                end else begin
                    chk("idle_regW_err", {30'd0, wb_regW, err}, 32'd0);
                end
            end
        end
    end

    task automatic clear_inputs();
        valid_in = 0; flush_in = 0; zero_in = 0; pcSel_in = 0;
        memR_in = 0; memW_in = 0; regW_in = 0; memToR_in = 0;
        BPC_in = 0; aluOut_in = 0; gprB_in = 0; gprDes_in = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] des, input logic rw);
        @(negedge clk);
        clear_inputs();
        valid_in = 1; aluOut_in = alu; gprDes_in = des; regW_in = rw;
        #1;
        chk("alu_stall", 32'(stall_out), 32'd0);
        push(0, rw, 0, des, alu, 32'd0);
    endtask

    // ack_at: WAIT cycle (1..16) on which ack is raised; 0 means never (timeout).
    task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [4:0] des, input logic rw,
                          input logic mtr, input int ack_at);
        bit done = 0;
        @(negedge clk);
        clear_inputs();
        valid_in = 1; memR_in = ~we; memW_in = we; aluOut_in = addr; gprB_in = wdata;
        gprDes_in = des; regW_in = rw; memToR_in = mtr;
        #1;
        chk("issue_stall", 32'(stall_out), 32'd1);
        chk("issue_no_req_yet", 32'(dmem_req), 32'd0);
        if (ack_at == 0) push(1, 0, 0, des, addr, 32'd0);
        else             push(0, rw, mtr, des, addr, we ? 32'd0 : rdata);
        for (int i = 1; i <= 16; i++) begin
            if (!done) begin
                @(negedge clk);
                // Held instruction plus a flush and branch condition: all must be ignored in WAIT.
                flush_in = 1; pcSel_in = 1; zero_in = 1;
                chk("wait_req", 32'(dmem_req), 32'd1);
                chk("wait_addr", dmem_addr, addr);
                chk("wait_we", 32'(dmem_we), 32'(we));
                if (we) chk("wait_wdata", dmem_wdata, wdata);
                if (i == ack_at) begin
                    dmem_ack = 1; dmem_rdata = rdata;
                    #1;
                    chk("ack_stall", 32'(stall_out), 32'd0);
                    done = 1;
                end else begin
                    #1;
                    chk("wait_stall", 32'(stall_out), 32'd1);
                end
                chk("wait_br_take", 32'(br_take), 32'd0);
            end
        end
        @(negedge clk);
        clear_inputs();
        chk("req_dropped", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        #3;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb", {29'd0, wb_valid, wb_regW, err}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst = 1;

        alu_op(32'h1234, 5'd5, 1'b1);
        alu_op(32'hCAFE_0001, 5'd31, 1'b0);

        mem_op(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1, 4);
        mem_op(1'b1, 32'h80, 32'hA5A5A5A5, 32'h1111_2222, 5'd3, 1'b0, 1'b0, 1);

        // Misaligned load and read+write together are both rejected without a request.
        @(negedge clk);
        clear_inputs();
        valid_in = 1; memR_in = 1; aluOut_in = 32'h42; gprDes_in = 5'd9; regW_in = 1;
        #1 chk("misalign_stall", 32'(stall_out), 32'd0);
        push(1, 0, 0, 5'd9, 32'h42, 32'd0);
        @(negedge clk);
        memW_in = 1; aluOut_in = 32'h44;
        chk("misalign_no_req", 32'(dmem_req), 32'd0);
        #1 chk("rw_stall", 32'(stall_out), 32'd0);
        push(1, 0, 0, 5'd9, 32'h44, 32'd0);
        @(negedge clk);
        clear_inputs();
        chk("rw_no_req", 32'(dmem_req), 32'd0);

        mem_op(1'b0, 32'h100, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 0);
        mem_op(1'b0, 32'h104, 32'h0, 32'h7777_8888, 5'd6, 1'b1, 1'b1, 16);

        // Branch resolution.
        @(negedge clk);
        clear_inputs();
        valid_in = 1; pcSel_in = 1; zero_in = 1; BPC_in = 32'h200; aluOut_in = 32'h5; gprDes_in = 5'd0;
        #1;
        chk("br_take_taken", 32'(br_take), 32'd1);
        chk("br_target", br_target, 32'h200);
        push(0, 0, 0, 5'd0, 32'h5, 32'd0);
        @(negedge clk);
        zero_in = 0;
        #1 chk("br_take_notzero", 32'(br_take), 32'd0);
        push(0, 0, 0, 5'd0, 32'h5, 32'd0);
        @(negedge clk);
        zero_in = 1; flush_in = 1; regW_in = 1;
        #1 chk("br_take_flush", 32'(br_take), 32'd0);
        @(negedge clk);
        clear_inputs();

        // Reset asserted while a load is outstanding.
        @(negedge clk);
        valid_in = 1; memR_in = 1; aluOut_in = 32'h300; gprDes_in = 5'd2; regW_in = 1;
        @(negedge clk);
        clear_inputs();
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_stall", 32'(stall_out), 32'd0);
        chk("midrst_addr", dmem_addr, 32'd0);
        chk("midrst_wb", {29'd0, wb_valid, wb_regW, err}, 32'd0);
        @(negedge clk);
        rst = 1;
        mem_op(1'b0, 32'h304, 32'h0, 32'h0BAD_F00D, 5'd12, 1'b1, 1'b1, 2);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX/MEM register.
- Consumes the EX/MEM register's outputs, performs data-memory loads and stores over a req/ack handshake that may take several cycles, resolves branches, and produces registered fields for the MEM/WB register.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- DATA_W, 32, data/address width.
- TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting with an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- valid_in  in  1  EX/MEM holds a live instruction
- flush_in  in  1  discard the instruction in IDLE this cycle
- BPC_in  in  32  branch target
- gprDes_in  in  5  destination register
- aluOut_in  in  32  ALU result / memory address
- gprB_in  in  32  store data
- zero_in  in  1  ALU zero flag
- pcSel_in  in  1  instruction is a branch
- memR_in, memW_in, regW_in, memToR_in  in  1 each  control bits
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  write data
- dmem_ack  in  1  memory completion
- dmem_rdata  in  32  read data, valid with dmem_ack
- stall_out  out  1  drives EX/MEM Write low (0 = freeze)
- br_take  out  1  redirect PC this cycle
- br_target  out  32  redirect address
- wb_valid  out  1  one-cycle retire pulse
- wb_regW, wb_memToR  out  1 each  control to MEM/WB
- wb_gprDes  out  5  destination register
- wb_aluOut  out  32  ALU result
- wb_rdata  out  32  load data
- err  out  1  one-cycle error pulse

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, timeout counter=0.
  - All registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, err.
- FSM has two states, IDLE and WAIT.
- IDLE, valid_in=1, flush_in=0:
  - Non-memory op (memR=memW=0):
    - Next edge: wb_valid=1; wb_regW, wb_memToR, wb_gprDes, wb_aluOut copied from inputs; wb_rdata=0.
    - Latency 1 cycle. stall_out=0.
  - Memory op, legal (exactly one of memR/memW set, aluOut_in[1:0]=0):
    - stall_out=1 combinationally in the same cycle.
    - Next edge: dmem_req=1, dmem_we=memW_in, dmem_addr=aluOut_in, dmem_wdata=gprB_in.
    - Control fields latched internally; state→WAIT; counter=0.
  - Illegal (memR&memW, or misaligned address):
    - No request is issued.
    - Next edge: err=1, wb_valid=1, wb_regW=0 (write suppressed). stall_out=0.
- IDLE with valid_in=0 or flush_in=1: wb_valid=0, wb_regW=0; nothing is issued.
- WAIT:
  - stall_out=1.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - Counter increments each cycle without ack.
  - dmem_ack=1:
    - Next edge: dmem_req=0, state→IDLE, wb_valid=1, latched control to wb_*.
    - wb_rdata=dmem_rdata for a read, 0 for a write.
    - stall_out drops combinationally in the ack cycle, so upstream advances on that same edge.
    - Minimum load/store latency is 2 cycles (issue + ack).
  - Counter reaches TIMEOUT-1 with no ack:
    - Next edge: dmem_req=0, state→IDLE, err=1, wb_valid=1, wb_regW=0.
  - An ack arriving on the timeout cycle wins: normal completion, err=0.
  - flush_in is ignored in WAIT; the outstanding access completes.
- Branch resolution (combinational, IDLE only):
  - br_take = valid_in & ~flush_in & pcSel_in & zero_in.
  - br_target = BPC_in.
  - br_take=0 whenever state=WAIT.
- wb_valid, err: single-cycle pulses. When wb_valid=0, wb_regW=0.
- Reset asserted mid-WAIT: immediate return to IDLE, dmem_req=0, and the access is abandoned.

Test Plan:
- Reset, then an ALU op (aluOut=0x1234, gprDes=5, regW=1): one cycle later wb_valid=1, wb_aluOut=0x1234, wb_gprDes=5; stall_out never asserted.
- Load addr 0x40, ack after 3 wait cycles with rdata=0xDEADBEEF:
  - stall_out high for 4 cycles; dmem_addr stable at 0x40.
  - wb_rdata=0xDEADBEEF, wb_memToR=1, single wb_valid pulse.
- Store addr 0x80, gprB=0xA5A5A5A5, immediate ack: dmem_we=1, dmem_wdata=0xA5A5A5A5, wb_valid=1 with wb_regW=0.
- Load addr 0x42 (misaligned): no dmem_req; err=1 and wb_valid=1 with wb_regW=0.
- Load with no ack, TIMEOUT=16: dmem_req drops after 16 cycles; err=1; state back to IDLE. Repeat with ack on cycle 16: err=0, normal completion.
- Branch checks:
  - pcSel=1, zero=1, BPC=0x200 → br_take=1, br_target=0x200 in the same cycle.
  - zero=0 → br_take=0.
  - flush_in=1 → br_take=0 and no wb_valid.
- rst=0 pulsed mid-WAIT: all outputs 0 immediately; next legal load starts cleanly.
